if_prefetch_buffer: RTL and testbench
=====================================

# if_prefetch_buffer

Parametrised instruction-fetch front end for the 5-stage RV32 pipeline. It issues requests to instruction memory through a request/grant/response handshake that tolerates variable latency, and keeps up to DEPTH instructions in flight or buffered. It delivers instruction/PC pairs to decode over a valid/ready handshake. On a redirect from the branch/flush unit it discards all buffered and in-flight fetches.

## Interface
- ADDR_W, 32, fetch address / PC width
- INST_W, 32, instruction width
- DEPTH, 4, buffer slots; power of two, ≥2; also the bound on in-flight plus buffered fetches
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- fetch_req_o  out  1  fetch request valid
- fetch_pc_o  out  ADDR_W  address of current request
- fetch_gnt_i  in  1  request accepted this cycle when fetch_req_o=1
- fetch_rvalid_i  in  1  response valid; responses return in request order, ≥1 cycle after grant
- fetch_inst_i  in  INST_W  response data, qualified by fetch_rvalid_i
- redirect_i  in  1  flush and restart fetch (branch taken / flush)
- redirect_pc_i  in  ADDR_W  new fetch address, qualified by redirect_i
- id_valid_o  out  1  head instruction available to decode
- id_ready_i  in  1  decode accepts head
- id_inst_o  out  INST_W  head instruction
- id_pc_o  out  ADDR_W  PC of head instruction
- count_o  out  $clog2(DEPTH)+1  filled, un-popped slots

## Operation
- State: pc_q; slot arrays inst[DEPTH], pc[DEPTH], full[DEPTH]; wr_ptr (reserve), fill_ptr, rd_ptr, each $clog2(DEPTH)+1 bits with wrap bit; drop_cnt ($clog2(DEPTH)+1 bits); run_q.
- reserved = wr_ptr − rd_ptr (modular). Slots between fill_ptr and wr_ptr are in flight.
- fetch_req_o = run_q & !redirect_i & (reserved + drop_cnt < DEPTH).
- Issue (req & gnt): reserve slot wr_ptr, store pc[wr_ptr]=pc_q, clear full[wr_ptr], wr_ptr+1, pc_q+4. pc_q wraps modulo 2^ADDR_W.
- Response (rvalid):
  - If drop_cnt>0, discard the data and decrement drop_cnt.
  - Otherwise write inst[fill_ptr], set full[fill_ptr], fill_ptr+1.
- Pop (id_valid_o & id_ready_i): rd_ptr+1. id_valid_o = full[rd_ptr] & (rd_ptr≠fill_ptr) & !redirect_i. id_inst_o/id_pc_o come from slot rd_ptr.
- count_o = fill_ptr − rd_ptr.
- Redirect (redirect_i=1), with priority over everything else in that cycle:
  - pc_q←redirect_pc_i.
  - rd_ptr, fill_ptr←wr_ptr.
  - drop_cnt←drop_cnt + (wr_ptr−fill_ptr) − (rvalid ? 1 : 0).
  - All full bits cleared.
  - No issue or pop occurs that cycle; a response arriving that cycle is discarded.
- rvalid with no in-flight fetch and drop_cnt=0 is a protocol error; state is unchanged. The bench asserts on it.
- run_q is 0 in reset and becomes 1 on the first clock after rst_n deasserts.

## Timing
- Reset values: pc_q=RESET_PC, so fetch_pc_o=RESET_PC; all pointers=0; drop_cnt=0; full=0; run_q=0. Therefore fetch_req_o=0, id_valid_o=0, count_o=0, id_inst_o=0, id_pc_o=0.
- First fetch_req_o=1 occurs one cycle after rst_n release.
- Issue throughput: one per cycle while gnt=1 and space remains.
- Response at edge N (rvalid sampled) gives id_valid_o=1 in cycle N+1. There is no combinational path rvalid→id_valid_o.
- The only combinational inputs to outputs are:
  - redirect_i gating fetch_req_o and id_valid_o;
  - gnt-independent fetch_req_o (fetch_req_o never depends on fetch_gnt_i).
- Full: reserved+drop_cnt=DEPTH forces fetch_req_o=0. A pop in the same cycle frees space from the next cycle only.
- Empty: id_valid_o=0. A response and a pop to/from different slots in the same cycle are both performed.
- After redirect at edge N: the first request at redirect_pc_i is in cycle N+1, and the first deliverable instruction is its response.
- Back-to-back redirects: each reloads pc_q. drop_cnt accumulates and never exceeds DEPTH.
- Reset asserted mid-operation: all state clears immediately (asynchronously). In-flight responses after reset are the memory's responsibility; memory is reset together with this block.

## Test plan
- Zero-stall stream: gnt=1, rvalid 1 cycle after each grant, id_ready=1 → id_pc_o sequence 0,4,8,12… with one instruction per cycle; count_o ≤1.
- Backpressure: id_ready=0, DEPTH=4, gnt=1 → exactly 4 grants (PC 0..12), then fetch_req_o=0 and count_o=4. Asserting id_ready then pops 0,4,8,12 in order, and fetch resumes at 16.
- Variable latency: responses 1,3,2 cycles after grants (in order) → id_inst_o values match request order and each appears the cycle after its rvalid.
- Redirect with 2 in flight: redirect_pc_i=0x100 → the 2 stale responses are dropped (drop_cnt 2→0). The next delivered pair is 0x100/inst@0x100, and no stale PC reaches decode.
- Redirect while full, with a simultaneous pop and rvalid → no pop is recorded and the rvalid is discarded. Next cycle count_o=0 and fetch_pc_o=redirect_pc_i.
- Async reset mid-stream → outputs return to reset values immediately. The first request after release is RESET_PC, one cycle after release.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer
//
// Instruction-fetch front end for the 5-stage RV32 pipeline. It issues
// sequential fetches to instruction memory over a request/grant/response
// handshake with variable latency. It keeps at most DEPTH fetches either in
// flight or buffered, and hands instruction/PC pairs to decode over a
// valid/ready handshake. A redirect drops everything buffered. Fetches that
// are still in flight are not cancelled at the memory; their responses are
// counted off and discarded when they return.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   fetch_req_o      request valid (never depends on fetch_gnt_i)
//   fetch_pc_o       address of the current request
//   fetch_gnt_i      request accepted this cycle
//   fetch_rvalid_i   in-order response valid, fetch_inst_i carries data
//   redirect_i       flush and restart at redirect_pc_i
//   id_valid_o       head instruction available to decode
//   id_ready_i       decode accepts the head
//   id_inst_o        head instruction
//   id_pc_o          PC of the head instruction
//   count_o          filled, not yet popped slots
module if_prefetch_buffer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     fetch_req_o,
  output logic [ADDR_W-1:0]        fetch_pc_o,
  input  logic                     fetch_gnt_i,
  input  logic                     fetch_rvalid_i,
  input  logic [INST_W-1:0]        fetch_inst_i,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [INST_W-1:0]        id_inst_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam logic [PW:0] DEPTH_V = (PW + 1)'(DEPTH);

  // Fetch-side state
  logic [ADDR_W-1:0] pc_q;
  logic              run_q;

  // Slot storage and pointers. Each pointer carries one wrap bit, so a
  // full ring and an empty ring can be told apart.
  logic [INST_W-1:0] inst_q    [DEPTH];
  logic [ADDR_W-1:0] slot_pc_q [DEPTH];
  logic [DEPTH-1:0]  full_q;
  logic [DEPTH-1:0]  full_next;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     fill_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     drop_cnt_q;

  logic [PW-1:0]     reserved;
  logic [PW-1:0]     in_flight;
  logic [PW:0]       occupancy;
  logic [PW-1:0]     redirect_drop;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     fill_idx;
  logic [IW-1:0]     rd_idx;
  logic              issue;
  logic              pop;
  logic              rsp_ok;
  logic              rsp_drop;
  logic              rsp_fill;

  assign wr_idx   = wr_ptr_q[IW-1:0];
  assign fill_idx = fill_ptr_q[IW-1:0];
  assign rd_idx   = rd_ptr_q[IW-1:0];

  assign reserved  = wr_ptr_q - rd_ptr_q;
  assign in_flight = wr_ptr_q - fill_ptr_q;
  // Fetches still owed to a previous redirect hold their budget until they
  // return. Without this, the ring could be overrun by stale responses.
  assign occupancy = {1'b0, reserved} + {1'b0, drop_cnt_q};

  assign fetch_req_o = run_q & ~redirect_i & (occupancy < DEPTH_V);
  assign fetch_pc_o  = pc_q;
  assign issue       = fetch_req_o & fetch_gnt_i;

  assign id_valid_o = full_q[rd_idx] & (rd_ptr_q != fill_ptr_q) & ~redirect_i;
  assign pop        = id_valid_o & id_ready_i;
  assign id_inst_o  = inst_q[rd_idx];
  assign id_pc_o    = slot_pc_q[rd_idx];
  assign count_o    = fill_ptr_q - rd_ptr_q;

  // A response with nothing outstanding is a protocol error. It is ignored,
  // so no counter can underflow.
  assign rsp_drop = fetch_rvalid_i & (drop_cnt_q != '0);
  assign rsp_fill = fetch_rvalid_i & (drop_cnt_q == '0) & (in_flight != '0);
  assign rsp_ok   = rsp_drop | rsp_fill;

  // On a redirect every in-flight fetch becomes stale. A legal response in
  // the same cycle is one of those fetches, so it is discarded on the spot.
  assign redirect_drop = drop_cnt_q + in_flight - PW'(rsp_ok);

  always_comb begin
    full_next = full_q;
    if (redirect_i) begin
      full_next = '0;
    end else begin
      if (issue)    full_next[wr_idx]   = 1'b0;
      if (rsp_fill) full_next[fill_idx] = 1'b1;
    end
  end

  // Stage boundary: control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      full_q     <= '0;
    end else begin
      run_q  <= 1'b1;
      full_q <= full_next;
      if (redirect_i) begin
        pc_q       <= redirect_pc_i;
        rd_ptr_q   <= wr_ptr_q;
        fill_ptr_q <= wr_ptr_q;
        drop_cnt_q <= redirect_drop;
      end else begin
        if (issue) begin
          pc_q     <= pc_q + ADDR_W'(4);
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (rsp_drop) drop_cnt_q <= drop_cnt_q - PW'(1);
        if (rsp_fill) fill_ptr_q <= fill_ptr_q + PW'(1);
        if (pop)      rd_ptr_q   <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Stage boundary: slot data (cleared so idle outputs read as zero)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_q[i]    <= '0;
        slot_pc_q[i] <= '0;
      end
    end else begin
      if (issue)                   slot_pc_q[wr_idx] <= pc_q;
      if (rsp_fill && !redirect_i) inst_q[fill_idx]  <= fetch_inst_i;
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
module tb_if_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_gnt_i = 1'b0;
  logic        fetch_rvalid_i = 1'b0;
  logic [31:0] fetch_inst_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;
  int grants = 0;
  logic [31:0] pend[$];
  bit auto_rsp = 1'b0;

  if_prefetch_buffer #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_o(fetch_req_o), .fetch_pc_o(fetch_pc_o), .fetch_gnt_i(fetch_gnt_i),
    .fetch_rvalid_i(fetch_rvalid_i), .fetch_inst_i(fetch_inst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_inst_o(id_inst_o), .id_pc_o(id_pc_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  // One clock: record any grant, then play the memory side after the edge.
  task automatic tick();
    logic g;
    logic [31:0] p;
    #1;
    g = fetch_req_o & fetch_gnt_i;
    p = fetch_pc_o;
    @(posedge clk);
    #1;
    fetch_rvalid_i = 1'b0;
    if (g) begin
      pend.push_back(p);
      grants++;
    end
    if (auto_rsp && pend.size() > 0) begin
      fetch_rvalid_i = 1'b1;
      fetch_inst_i = inst_of(pend.pop_front());
    end
  endtask

  task automatic send_rsp();
    checks++;
    if (pend.size() == 0) begin
      errors++;
      $display("FAIL rsp_protocol: outstanding=%0d required>0", pend.size());
    end else begin
      fetch_rvalid_i = 1'b1;
      fetch_inst_i = inst_of(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    fetch_gnt_i = 0; id_ready_i = 0; redirect_i = 0; fetch_rvalid_i = 0;
    auto_rsp = 0; rst_n = 0; grants = 0;
    pend.delete();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", fetch_req_o); end
    checks++; if (fetch_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", fetch_pc_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", id_valid_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if (id_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", id_inst_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_idpc: got %h want 0", id_pc_o); end
    tick();
    rst_n = 1;
    #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL release_req0: got %0b want 0", fetch_req_o); end
    tick();
    checks++; if (fetch_req_o !== 1'b1) begin errors++; $display("FAIL release_req1: got %0b want 1", fetch_req_o); end
    checks++; if (fetch_pc_o !== 32'h0) begin errors++; $display("FAIL release_pc: got %h want 0", fetch_pc_o); end
  endtask

  task automatic test_stream();
    do_reset();
    auto_rsp = 1; fetch_gnt_i = 1; id_ready_i = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", k, id_valid_o); end
      checks++; if (id_pc_o !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, id_pc_o, 32'(4 * k)); end
      checks++; if (id_inst_o !== inst_of(32'(4 * k))) begin errors++; $display("FAIL stream_inst[%0d]: got %h want %h", k, id_inst_o, inst_of(32'(4 * k))); end
      checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", k, count_o); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    auto_rsp = 1; fetch_gnt_i = 1; id_ready_i = 0;
    repeat (5) tick();
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL bp_req: got %0b want 0", fetch_req_o); end
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d want 4", count_o); end
    checks++; if (grants != 4) begin errors++; $display("FAIL bp_grants: got %0d want 4", grants); end
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin errors++; $display("FAIL bp_head: got valid=%0b pc=%h want 1/0", id_valid_o, id_pc_o); end
    repeat (3) tick();
    checks++; if (grants != 4 || fetch_req_o !== 1'b0) begin errors++; $display("FAIL bp_hold: got grants=%0d req=%0b want 4/0", grants, fetch_req_o); end
    id_ready_i = 1;
    #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL bp_samecycle_req: got %0b want 0", fetch_req_o); end
    tick();
    checks++; if (id_pc_o !== 32'h4) begin errors++; $display("FAIL bp_pop1: got %h want 4", id_pc_o); end
    checks++; if (fetch_req_o !== 1'b1 || fetch_pc_o !== 32'h10) begin errors++; $display("FAIL bp_resume: got req=%0b pc=%h want 1/10", fetch_req_o, fetch_pc_o); end
    tick();
    checks++; if (id_pc_o !== 32'h8) begin errors++; $display("FAIL bp_pop2: got %h want 8", id_pc_o); end
    tick();
    checks++; if (id_pc_o !== 32'hC) begin errors++; $display("FAIL bp_pop3: got %h want c", id_pc_o); end
    tick();
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h10 || id_inst_o !== inst_of(32'h10)) begin
      errors++; $display("FAIL bp_next: got valid=%0b pc=%h inst=%h want 1/10/%h", id_valid_o, id_pc_o, id_inst_o, inst_of(32'h10));
    end
  endtask

  task automatic test_latency();
    bit gv[7];
    bit rv[7];
    int n;
    gv = '{1, 1, 0, 0, 1, 0, 0};
    rv = '{0, 1, 0, 0, 1, 0, 1};
    n = 0;
    do_reset();
    auto_rsp = 0; id_ready_i = 1;
    for (int c = 0; c < 7; c++) begin
      fetch_gnt_i = gv[c];
      if (rv[c]) begin
        send_rsp();
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL lat_comb[%0d]: got %0b want 0", c, id_valid_o); end
      end
      tick();
      checks++; if (id_valid_o !== rv[c]) begin errors++; $display("FAIL lat_valid[%0d]: got %0b want %0b", c, id_valid_o, rv[c]); end
      if (rv[c]) begin
        checks++; if (id_pc_o !== 32'(4 * n) || id_inst_o !== inst_of(32'(4 * n))) begin
          errors++; $display("FAIL lat_data[%0d]: got pc=%h inst=%h want %h/%h", c, id_pc_o, id_inst_o, 32'(4 * n), inst_of(32'(4 * n)));
        end
        n++;
      end
    end
    fetch_gnt_i = 0;
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    auto_rsp = 0; id_ready_i = 1; fetch_gnt_i = 1;
    tick(); tick();
    redirect_i = 1; redirect_pc_i = 32'h100;
    #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL rdi_gate: got %0b want 0", fetch_req_o); end
    tick();
    redirect_i = 0;
    #1;
    checks++; if (fetch_req_o !== 1'b1 || fetch_pc_o !== 32'h100) begin errors++; $display("FAIL rdi_restart: got req=%0b pc=%h want 1/100", fetch_req_o, fetch_pc_o); end
    tick();
    fetch_gnt_i = 0;
    checks++; if (fetch_pc_o !== 32'h104) begin errors++; $display("FAIL rdi_next_pc: got %h want 104", fetch_pc_o); end
    for (int s = 0; s < 2; s++) begin
      send_rsp();
      tick();
      checks++; if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL rdi_stale[%0d]: got valid=%0b count=%0d want 0/0", s, id_valid_o, count_o); end
    end
    send_rsp();
    tick();
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100 || id_inst_o !== inst_of(32'h100)) begin
      errors++; $display("FAIL rdi_first: got valid=%0b pc=%h inst=%h want 1/100/%h", id_valid_o, id_pc_o, id_inst_o, inst_of(32'h100));
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    auto_rsp = 1; fetch_gnt_i = 1; id_ready_i = 0;
    repeat (4) tick();
    checks++; if (count_o !== 3'd3 || fetch_req_o !== 1'b0 || id_valid_o !== 1'b1) begin
      errors++; $display("FAIL rdf_pre: got count=%0d req=%0b valid=%0b want 3/0/1", count_o, fetch_req_o, id_valid_o);
    end
    auto_rsp = 0; id_ready_i = 1; redirect_i = 1; redirect_pc_i = 32'h200;
    #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rdf_gate: got %0b want 0", id_valid_o); end
    tick();
    redirect_i = 0;
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rdf_count: got %0d want 0", count_o); end
    checks++; if (fetch_pc_o !== 32'h200 || fetch_req_o !== 1'b1) begin errors++; $display("FAIL rdf_pc: got pc=%h req=%0b want 200/1", fetch_pc_o, fetch_req_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rdf_valid: got %0b want 0", id_valid_o); end
    auto_rsp = 1;
    tick(); tick();
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200 || id_inst_o !== inst_of(32'h200)) begin
      errors++; $display("FAIL rdf_first: got valid=%0b pc=%h inst=%h want 1/200/%h", id_valid_o, id_pc_o, id_inst_o, inst_of(32'h200));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    auto_rsp = 0; id_ready_i = 1; fetch_gnt_i = 1;
    tick(); tick();
    redirect_i = 1; redirect_pc_i = 32'h300;
    tick();
    redirect_i = 0;
    #1;
    checks++; if (fetch_pc_o !== 32'h300) begin errors++; $display("FAIL b2b_pc1: got %h want 300", fetch_pc_o); end
    tick();
    redirect_i = 1; redirect_pc_i = 32'h400;
    tick();
    redirect_i = 0;
    #1;
    checks++; if (fetch_pc_o !== 32'h400 || fetch_req_o !== 1'b1) begin errors++; $display("FAIL b2b_pc2: got pc=%h req=%0b want 400/1", fetch_pc_o, fetch_req_o); end
    tick();
    fetch_gnt_i = 0;
    #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL b2b_budget: got %0b want 0", fetch_req_o); end
    send_rsp();
    tick();
    checks++; if (fetch_req_o !== 1'b1 || id_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drop1: got req=%0b valid=%0b want 1/0", fetch_req_o, id_valid_o); end
    for (int s = 0; s < 2; s++) begin
      send_rsp();
      tick();
      checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_stale[%0d]: got %0b want 0", s, id_valid_o); end
    end
    send_rsp();
    tick();
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h400 || id_inst_o !== inst_of(32'h400)) begin
      errors++; $display("FAIL b2b_first: got valid=%0b pc=%h inst=%h want 1/400/%h", id_valid_o, id_pc_o, id_inst_o, inst_of(32'h400));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    auto_rsp = 1; fetch_gnt_i = 1; id_ready_i = 0;
    repeat (3) tick();
    checks++; if (count_o !== 3'd2 || fetch_pc_o !== 32'hC) begin errors++; $display("FAIL ar_pre: got count=%0d pc=%h want 2/c", count_o, fetch_pc_o); end
    #2;
    rst_n = 0; auto_rsp = 0; fetch_rvalid_i = 0; fetch_gnt_i = 0;
    #1;
    checks++; if (fetch_req_o !== 1'b0 || fetch_pc_o !== 32'h0) begin errors++; $display("FAIL ar_fetch: got req=%0b pc=%h want 0/0", fetch_req_o, fetch_pc_o); end
    checks++; if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL ar_id: got valid=%0b count=%0d want 0/0", id_valid_o, count_o); end
    checks++; if (id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin errors++; $display("FAIL ar_data: got inst=%h pc=%h want 0/0", id_inst_o, id_pc_o); end
    pend.delete();
    tick();
    rst_n = 1;
    #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL ar_release0: got %0b want 0", fetch_req_o); end
    tick();
    checks++; if (fetch_req_o !== 1'b1 || fetch_pc_o !== 32'h0) begin errors++; $display("FAIL ar_release1: got req=%0b pc=%h want 1/0", fetch_req_o, fetch_pc_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect_inflight();
    test_redirect_full();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
